// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the single-cycle core.
// Owns the program counter, drives the combinational ROM address from the PC
// register, and registers each fetched word into a one-entry valid/ready output
// stage. Handles redirects, halt/resume and backpressure so the consumer never
// sees a stale or duplicated instruction.
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [1:0]        fetch_state,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // Force a redirect target onto a word boundary by clearing the byte offset.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  // A redirect target is misaligned when its byte offset is non-zero.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [INST_W-1:0] data_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              mis_q;

  logic              accept_d;
  logic              load_d;
  logic [ADDR_W-1:0] redir_target_d;
  logic              redir_mis_d;

  // Handshake, load-enable and redirect-target decode for the current cycle.
  always_comb begin
    accept_d       = 1'b0;
    load_d         = 1'b0;
    redir_target_d = align_word(redirect_pc);
    redir_mis_d    = is_misaligned(redirect_pc);
    accept_d       = valid_q & inst_ready;
    if (state_q == ST_RUN) begin
      load_d = ~redirect_valid & ~halt & (~valid_q | inst_ready);
    end else begin
      load_d = 1'b0;
    end
  end

  // Fetch FSM: PC, output stage, sticky misalign flag and state transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          // Settling cycle after reset release: no fetch, redirects ignored.
          state_q <= halt ? ST_DRAIN : ST_RUN;
        end

        ST_RUN: begin
          if (redirect_valid) begin
            // Flush wins over any handshake this cycle; no load in this cycle.
            pc_q    <= redir_target_d;
            valid_q <= 1'b0;
            mis_q   <= mis_q | redir_mis_d;
          end else if (halt) begin
            state_q <= ST_DRAIN;
            if (accept_d) begin
              valid_q <= 1'b0;
            end
          end else if (load_d) begin
            data_q  <= rom_data;
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + PC_STEP;
          end else begin
            // Backpressure: output stage and PC hold.
            valid_q <= valid_q;
          end
        end

        ST_DRAIN: begin
          if (redirect_valid) begin
            pc_q    <= redir_target_d;
            valid_q <= 1'b0;
            mis_q   <= mis_q | redir_mis_d;
            state_q <= ST_HALTED;
          end else if (!halt) begin
            // Halt withdrawn: resume with the held output intact.
            state_q <= ST_RUN;
            if (accept_d) begin
              valid_q <= 1'b0;
            end
          end else if (!valid_q || inst_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_HALTED;
          end else begin
            state_q <= ST_DRAIN;
          end
        end

        ST_HALTED: begin
          if (redirect_valid) begin
            pc_q    <= redir_target_d;
            valid_q <= 1'b0;
            mis_q   <= mis_q | redir_mis_d;
            state_q <= ST_RUN;
          end else if (!halt) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_HALTED;
          end
        end

        default: begin
          state_q <= ST_WAIT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr     = pc_q;
  assign inst_valid   = valid_q;
  assign inst_data    = data_q;
  assign inst_pc      = ipc_q;
  assign fetch_state  = state_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. The ROM returns a word equal to its
// own address, so inst_data must always match inst_pc.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic [1:0]  fetch_state;
  logic        misalign_err;

  int checks;
  int failures;

  fetch_sequencer #(.ADDR_W(8), .INST_W(32), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_state    (fetch_state),
    .misalign_err   (misalign_err)
  );

  assign rom_data = {24'h000000, rom_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset across one edge, release it mid-cycle, check the WAIT state.
  task automatic apply_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    halt = 1'b0;
    inst_ready = 1'b1;
    tick();
    reset = 1'b1;
    checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL rst_state actual=%0d required=%0d", fetch_state, 2'd0); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%0b required=%0b", inst_valid, 1'b0); end
    checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL rst_rom_addr actual=%h required=%h", rom_addr, 8'h00); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_misalign actual=%0b required=%0b", misalign_err, 1'b0); end
    checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL rst_data actual=%h required=%h", inst_data, 32'h0); end
    checks++; if (inst_pc !== 8'h00) begin failures++; $display("FAIL rst_inst_pc actual=%h required=%h", inst_pc, 8'h00); end
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL wait_to_run actual=%0d required=%0d", fetch_state, 2'd1); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL wait_nofetch actual=%0b required=%0b", inst_valid, 1'b0); end
  endtask

  // Streaming fetch across the full address space, including the wrap.
  task automatic test_stream_wrap();
    logic [7:0] exp_pc;
    apply_reset();
    tick();
    for (int k = 0; k <= 64; k++) begin
      tick();
      exp_pc = 8'(k * 4);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin failures++; $display("FAIL stream_pc k=%0d actual=%h/%0b required=%h/1", k, inst_pc, inst_valid, exp_pc); end
      checks++; if (inst_data !== {24'h0, exp_pc}) begin failures++; $display("FAIL stream_data k=%0d actual=%h required=%h", k, inst_data, {24'h0, exp_pc}); end
    end
    checks++; if (rom_addr !== 8'h04) begin failures++; $display("FAIL wrap_rom_addr actual=%h required=%h", rom_addr, 8'h04); end
  endtask

  // Consumer stalls three cycles with 0x10 in the output stage.
  task automatic test_backpressure();
    apply_reset();
    tick();
    for (int k = 0; k < 5; k++) tick();
    checks++; if (inst_pc !== 8'h10) begin failures++; $display("FAIL bp_setup actual=%h required=%h", inst_pc, 8'h10); end
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h10 || inst_data !== 32'h10) begin failures++; $display("FAIL bp_hold k=%0d actual=%h/%h/%0b required=10/10/1", k, inst_pc, inst_data, inst_valid); end
      checks++; if (rom_addr !== 8'h14) begin failures++; $display("FAIL bp_rom_addr k=%0d actual=%h required=%h", k, rom_addr, 8'h14); end
    end
    inst_ready = 1'b1;
    tick();
    checks++; if (inst_pc !== 8'h14 || inst_data !== 32'h14) begin failures++; $display("FAIL bp_resume actual=%h/%h required=14/14", inst_pc, inst_data); end
    tick();
    checks++; if (inst_pc !== 8'h18) begin failures++; $display("FAIL bp_next actual=%h required=%h", inst_pc, 8'h18); end
  endtask

  // Redirect while the output is valid and being accepted.
  task automatic test_redirect();
    apply_reset();
    tick();
    for (int k = 0; k < 4; k++) tick();
    checks++; if (inst_pc !== 8'h0C || inst_valid !== 1'b1) begin failures++; $display("FAIL redir_setup actual=%h/%0b required=0c/1", inst_pc, inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 8'h48;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_flush actual=%0b required=%0b", inst_valid, 1'b0); end
    checks++; if (rom_addr !== 8'h48) begin failures++; $display("FAIL redir_rom_addr actual=%h required=%h", rom_addr, 8'h48); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h48 || inst_data !== 32'h48) begin failures++; $display("FAIL redir_target actual=%h/%h/%0b required=48/48/1", inst_pc, inst_data, inst_valid); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL redir_no_mis actual=%0b required=%0b", misalign_err, 1'b0); end
  endtask

  // Misaligned redirect sets a sticky error that survives aligned redirects.
  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 8'h23;
    tick();
    redirect_valid = 1'b0;
    checks++; if (rom_addr !== 8'h20) begin failures++; $display("FAIL mis_align actual=%h required=%h", rom_addr, 8'h20); end
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_set actual=%0b required=%0b", misalign_err, 1'b1); end
    tick();
    checks++; if (inst_pc !== 8'h20) begin failures++; $display("FAIL mis_fetch actual=%h required=%h", inst_pc, 8'h20); end
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1 || rom_addr !== 8'h40) begin failures++; $display("FAIL mis_sticky actual=%0b/%h required=1/40", misalign_err, rom_addr); end
  endtask

  // Halt with a stalled output, drain on accept, then resume at the frozen PC.
  task automatic test_halt();
    apply_reset();
    tick();
    for (int k = 0; k < 3; k++) tick();
    inst_ready = 1'b0;
    halt = 1'b1;
    tick();
    checks++; if (fetch_state !== 2'd2 || inst_valid !== 1'b1 || inst_pc !== 8'h08) begin failures++; $display("FAIL halt_drain actual=%0d/%0b/%h required=2/1/08", fetch_state, inst_valid, inst_pc); end
    tick();
    checks++; if (fetch_state !== 2'd2 || inst_valid !== 1'b1) begin failures++; $display("FAIL halt_drain_hold actual=%0d/%0b required=2/1", fetch_state, inst_valid); end
    inst_ready = 1'b1;
    tick();
    checks++; if (fetch_state !== 2'd3 || inst_valid !== 1'b0) begin failures++; $display("FAIL halt_halted actual=%0d/%0b required=3/0", fetch_state, inst_valid); end
    tick();
    checks++; if (rom_addr !== 8'h0C || inst_valid !== 1'b0) begin failures++; $display("FAIL halt_frozen actual=%h/%0b required=0c/0", rom_addr, inst_valid); end
    halt = 1'b0;
    tick();
    checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL halt_resume_state actual=%0d required=%0d", fetch_state, 2'd1); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h0C) begin failures++; $display("FAIL halt_resume_pc actual=%h/%0b required=0c/1", inst_pc, inst_valid); end
  endtask

  // Halt dropped while draining: back to RUN with the held output kept.
  task automatic test_halt_release_in_drain();
    apply_reset();
    tick();
    tick();
    tick();
    inst_ready = 1'b0;
    halt = 1'b1;
    tick();
    checks++; if (fetch_state !== 2'd2) begin failures++; $display("FAIL hrel_drain actual=%0d required=%0d", fetch_state, 2'd2); end
    halt = 1'b0;
    tick();
    checks++; if (fetch_state !== 2'd1 || inst_valid !== 1'b1 || inst_pc !== 8'h04) begin failures++; $display("FAIL hrel_kept actual=%0d/%0b/%h required=1/1/04", fetch_state, inst_valid, inst_pc); end
    inst_ready = 1'b1;
    tick();
    checks++; if (inst_pc !== 8'h08) begin failures++; $display("FAIL hrel_next actual=%h required=%h", inst_pc, 8'h08); end
  endtask

  // A redirect during the WAIT cycle must be ignored.
  task automatic test_redirect_in_wait();
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc = 8'h81;
    tick();
    redirect_valid = 1'b0;
    checks++; if (rom_addr !== 8'h00 || misalign_err !== 1'b0) begin failures++; $display("FAIL wait_redir actual=%h/%0b required=00/0", rom_addr, misalign_err); end
  endtask

  // Asynchronous reset mid-cycle with a valid output and a sticky error.
  task automatic test_async_reset();
    apply_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 8'h31;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b1 || misalign_err !== 1'b1) begin failures++; $display("FAIL areset_setup actual=%0b/%0b required=1/1", inst_valid, misalign_err); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || misalign_err !== 1'b0 || fetch_state !== 2'd0) begin failures++; $display("FAIL areset_now actual=%0b/%0b/%0d required=0/0/0", inst_valid, misalign_err, fetch_state); end
    checks++; if (rom_addr !== 8'h00 || inst_pc !== 8'h00 || inst_data !== 32'h0) begin failures++; $display("FAIL areset_regs actual=%h/%h/%h required=00/00/0", rom_addr, inst_pc, inst_data); end
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    halt = 1'b0;
    inst_ready = 1'b1;
    test_reset();
    test_stream_wrap();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_halt_release_in_drain();
    test_redirect_in_wait();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
